// File: rtl/Purple_Jade_pkg.sv
// Shared commit-stage definitions: reorder-buffer geometry and the per-entry record.
package Purple_Jade_pkg;

  localparam int ROB_DEPTH    = 16;
  localparam int ROB_TAG_W    = $clog2(ROB_DEPTH);
  localparam int NUM_FU       = 2;
  localparam int NUM_PHYS_REG = 128;
  localparam int PHYS_W       = $clog2(NUM_PHYS_REG);
  localparam int NUM_FLAGS    = 4;

  // flag is {mask, values}; a set mask bit keeps the old architectural flag
  typedef struct packed {
    logic                   valid;
    logic                   done;
    logic                   has_dest;
    logic [PHYS_W-1:0]      old_phys;
    logic                   flag_w;
    logic [2*NUM_FLAGS-1:0] flag;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch at tail, out-of-order completion by tag,
// one registered commit per cycle from head into the register/flag state.
module reorder_buffer #(
  parameter int ROB_DEPTH    = Purple_Jade_pkg::ROB_DEPTH,
  parameter int NUM_FU       = Purple_Jade_pkg::NUM_FU,
  parameter int NUM_PHYS_REG = Purple_Jade_pkg::NUM_PHYS_REG,
  parameter int NUM_FLAGS    = Purple_Jade_pkg::NUM_FLAGS
) (
  input  logic                                           clk_i,
  input  logic                                           reset_n_i,
  input  logic                                           disp_v_i,
  output logic                                           disp_ready_o,
  input  logic                                           disp_has_dest_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0]                disp_old_phys_i,
  input  logic                                           disp_flag_w_i,
  output logic [$clog2(ROB_DEPTH)-1:0]                   disp_tag_o,
  input  logic [NUM_FU-1:0]                              exe_done_v_i,
  input  logic [NUM_FU-1:0][$clog2(ROB_DEPTH)-1:0]       exe_tag_i,
  input  logic [NUM_FU-1:0][NUM_FLAGS*2-1:0]             exe_flag_i,
  input  logic                                           flush_i,
  output logic                                           rob_phys_valid_o,
  output logic [$clog2(NUM_PHYS_REG)-1:0]                rob_phys_reg_cl_o,
  output logic                                           rob_flag_valid_o,
  output logic [NUM_FLAGS*2-1:0]                         rob_flag_o,
  output logic                                           commit_v_o,
  output logic                                           empty_o
);
  import Purple_Jade_pkg::*;

  localparam int TAG_W  = $clog2(ROB_DEPTH);
  localparam int CNT_W  = TAG_W + 1;
  localparam int PHY_W  = $clog2(NUM_PHYS_REG);
  localparam int FLAG_W = 2 * NUM_FLAGS;

  rob_entry_t [ROB_DEPTH-1:0] entries_reg, entries_next;
  logic [TAG_W-1:0]  head_reg, head_next, tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              commit_v_reg, commit_v_next;
  logic              phys_valid_reg, phys_valid_next;
  logic [PHY_W-1:0]  phys_reg_reg, phys_reg_next;
  logic              flag_valid_reg, flag_valid_next;
  logic [FLAG_W-1:0] flag_reg, flag_next;
  rob_entry_t        head_entry;
  logic              do_disp, do_commit;

  // Readiness looks only at registered occupancy, so a full buffer stalls
  // dispatch for the whole cycle even while the head retires.
  assign disp_ready_o = (count_reg != CNT_W'(ROB_DEPTH)) && !flush_i;
  assign disp_tag_o   = tail_reg;
  assign empty_o      = (count_reg == '0);
  assign head_entry   = entries_reg[head_reg];
  assign do_disp      = disp_v_i && disp_ready_o;
  assign do_commit    = head_entry.valid && head_entry.done && !flush_i;

  always_comb begin
    entries_next    = entries_reg;
    head_next       = head_reg;
    tail_next       = tail_reg;
    count_next      = count_reg;
    commit_v_next   = 1'b0;
    phys_valid_next = 1'b0;
    phys_reg_next   = '0;
    flag_valid_next = 1'b0;
    flag_next       = '0;
    if (flush_i) begin
      entries_next = '0;
      head_next    = '0;
      tail_next    = '0;
      count_next   = '0;
    end else begin
      // Later FUs overwrite earlier ones, so the highest index wins a shared tag.
      for (int i = 0; i < NUM_FU; i++) begin
        if (exe_done_v_i[i] && entries_reg[exe_tag_i[i]].valid) begin
          entries_next[exe_tag_i[i]].done = 1'b1;
          entries_next[exe_tag_i[i]].flag = exe_flag_i[i];
        end
      end
      if (do_commit) begin
        entries_next[head_reg] = '0;
        head_next              = head_reg + TAG_W'(1);
        commit_v_next          = 1'b1;
        phys_valid_next        = head_entry.has_dest;
        phys_reg_next          = head_entry.old_phys;
        flag_valid_next        = head_entry.flag_w;
        flag_next              = head_entry.flag;
      end
      if (do_disp) begin
        entries_next[tail_reg].valid    = 1'b1;
        entries_next[tail_reg].done     = 1'b0;
        entries_next[tail_reg].has_dest = disp_has_dest_i;
        entries_next[tail_reg].old_phys = disp_old_phys_i;
        entries_next[tail_reg].flag_w   = disp_flag_w_i;
        entries_next[tail_reg].flag     = '0;
        tail_next                       = tail_reg + TAG_W'(1);
      end
      if (do_disp && !do_commit) begin
        count_next = count_reg + CNT_W'(1);
      end else if (!do_disp && do_commit) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      entries_reg    <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      commit_v_reg   <= 1'b0;
      phys_valid_reg <= 1'b0;
      phys_reg_reg   <= '0;
      flag_valid_reg <= 1'b0;
      flag_reg       <= '0;
    end else begin
      entries_reg    <= entries_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      commit_v_reg   <= commit_v_next;
      phys_valid_reg <= phys_valid_next;
      phys_reg_reg   <= phys_reg_next;
      flag_valid_reg <= flag_valid_next;
      flag_reg       <= flag_next;
    end
  end

  assign commit_v_o        = commit_v_reg;
  assign rob_phys_valid_o  = phys_valid_reg;
  assign rob_phys_reg_cl_o = phys_reg_reg;
  assign rob_flag_valid_o  = flag_valid_reg;
  assign rob_flag_o        = flag_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;

  logic            clk_i = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            disp_v_i = 1'b0;
  logic            disp_ready_o;
  logic            disp_has_dest_i = 1'b0;
  logic [6:0]      disp_old_phys_i = '0;
  logic            disp_flag_w_i = 1'b0;
  logic [3:0]      disp_tag_o;
  logic [1:0]      exe_done_v_i = '0;
  logic [1:0][3:0] exe_tag_i = '0;
  logic [1:0][7:0] exe_flag_i = '0;
  logic            flush_i = 1'b0;
  logic            rob_phys_valid_o;
  logic [6:0]      rob_phys_reg_cl_o;
  logic            rob_flag_valid_o;
  logic [7:0]      rob_flag_o;
  logic            commit_v_o;
  logic            empty_o;

  reorder_buffer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .disp_v_i(disp_v_i), .disp_ready_o(disp_ready_o),
    .disp_has_dest_i(disp_has_dest_i), .disp_old_phys_i(disp_old_phys_i),
    .disp_flag_w_i(disp_flag_w_i), .disp_tag_o(disp_tag_o),
    .exe_done_v_i(exe_done_v_i), .exe_tag_i(exe_tag_i), .exe_flag_i(exe_flag_i),
    .flush_i(flush_i),
    .rob_phys_valid_o(rob_phys_valid_o), .rob_phys_reg_cl_o(rob_phys_reg_cl_o),
    .rob_flag_valid_o(rob_flag_valid_o), .rob_flag_o(rob_flag_o),
    .commit_v_o(commit_v_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int       tag;
    bit       hd;
    bit [6:0] op;
    bit       fw;
    bit       done;
    bit [7:0] flag;
  } m_ent_t;

  typedef struct {
    int       cyc;
    bit       hd;
    bit [6:0] op;
    bit       fw;
    bit [7:0] flag;
  } exp_t;

  m_ent_t mq[$];
  exp_t   exp_q[$];
  int     next_tag = 0;
  int     edge_cnt = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  exp_t   mon_e;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every retirement the DUT presents is matched to the oldest prediction.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (commit_v_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", commit_v_o, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_cycle", edge_cnt, mon_e.cyc);
          chk("phys_valid", rob_phys_valid_o, mon_e.hd);
          chk("phys_reg_cl", rob_phys_reg_cl_o, mon_e.op);
          chk("flag_valid", rob_flag_valid_o, mon_e.fw);
          chk("flag", rob_flag_o, mon_e.flag);
        end
      end else begin
        chk("idle_phys_valid", rob_phys_valid_o, 0);
        chk("idle_flag_valid", rob_flag_valid_o, 0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
          chk("missing_commit", commit_v_o, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; the model advances exactly as the spec's rules say.
  task automatic step(input bit dv, input bit hd, input bit [6:0] op, input bit fw,
                      input bit [1:0] dn, input bit [3:0] t0, input bit [3:0] t1,
                      input bit [7:0] f0, input bit [7:0] f1, input bit fl);
    bit       com;
    int       sz;
    bit [3:0] tg[2];
    bit [7:0] fg[2];
    exp_t     e;
    m_ent_t   n;
    @(negedge clk_i); #1;
    disp_v_i = 0; flush_i = 0; exe_done_v_i = '0; #1;
    chk("disp_ready", disp_ready_o, mq.size() < 16);
    chk("disp_tag", disp_tag_o, next_tag);
    chk("empty", empty_o, mq.size() == 0);
    disp_v_i = dv; disp_has_dest_i = hd; disp_old_phys_i = op; disp_flag_w_i = fw;
    exe_done_v_i = dn; exe_tag_i[0] = t0; exe_tag_i[1] = t1;
    exe_flag_i[0] = f0; exe_flag_i[1] = f1; flush_i = fl;
    tg[0] = t0; tg[1] = t1; fg[0] = f0; fg[1] = f1;
    if (fl) begin
      mq.delete();
      next_tag = 0;
    end else begin
      sz  = mq.size();
      com = (sz > 0) && mq[0].done;
      if (com) begin
        e.cyc = edge_cnt + 1; e.hd = mq[0].hd; e.op = mq[0].op;
        e.fw = mq[0].fw; e.flag = mq[0].flag;
        exp_q.push_back(e);
      end
      for (int i = 0; i < 2; i++)
        if (dn[i])
          for (int j = 0; j < sz; j++)
            if (mq[j].tag == int'(tg[i])) begin
              mq[j].done = 1;
              mq[j].flag = fg[i];
            end
      if (com) void'(mq.pop_front());
      if (dv && sz < 16) begin
        n.tag = next_tag; n.hd = hd; n.op = op; n.fw = fw; n.done = 0; n.flag = 0;
        mq.push_back(n);
        next_tag = (next_tag + 1) % 16;
      end
    end
    @(posedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic disp(input bit hd, input bit [6:0] op, input bit fw);
    step(1, hd, op, fw, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk_i); #2;
    disp_v_i = 0; flush_i = 0; exe_done_v_i = '0;
    reset_n_i = 0; #1;
    chk("rst_disp_ready", disp_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_disp_tag", disp_tag_o, 0);
    chk("rst_commit_v", commit_v_o, 0);
    chk("rst_phys_valid", rob_phys_valid_o, 0);
    chk("rst_phys_reg", rob_phys_reg_cl_o, 0);
    chk("rst_flag_valid", rob_flag_valid_o, 0);
    chk("rst_flag", rob_flag_o, 0);
    mq.delete(); exp_q.delete(); next_tag = 0;
    repeat (2) @(negedge clk_i);
    #2 reset_n_i = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit [1:0] dn;
    bit [3:0] t[2];
    apply_reset();

    // in-order retire despite out-of-order completion
    disp(1, 17, 0); disp(1, 18, 0); disp(1, 19, 0);
    step(0, 0, 0, 0, 2'b01, 2, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0);
    idle(4);

    // flush with six pending, head done
    for (int k = 0; k < 6; k++) disp(1, 7'(40 + k), 0);
    step(0, 0, 0, 0, 2'b01, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // fill, stall, wrap
    for (int k = 0; k < 17; k++) disp(1, 7'(k), 0);
    step(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    idle(1);
    disp(1, 99, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // flags, same-cycle dispatch/complete, two FUs on one tag
    disp(1, 5, 1);
    disp(0, 6, 0);
    step(0, 0, 0, 0, 2'b11, 0, 1, 8'hA5, 8'h3C, 0);
    idle(3);
    step(1, 1, 7, 1, 2'b01, 2, 0, 8'hFF, 0, 0);
    step(0, 0, 0, 0, 2'b11, 2, 2, 8'h11, 8'h22, 0);
    idle(3);

    // dispatch and commit in the same cycle at count 5
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) disp(1, 7'(60 + k), 0);
    step(0, 0, 0, 0, 2'b01, 0, 0, 8'h0F, 0, 0);
    disp(1, 70, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // randomized traffic, with one asynchronous reset midway
    for (int k = 0; k < 700; k++) begin
      if (k == 350) apply_reset();
      for (int i = 0; i < 2; i++) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          t[i] = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
        else
          t[i] = 4'($urandom_range(0, 15));
      end
      dn = 2'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 6, 1'($urandom), 7'($urandom), 1'($urandom),
           dn, t[0], t[1], 8'($urandom), 8'($urandom), $urandom_range(0, 49) == 0);
    end

    // drain everything still outstanding
    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      step(0, 0, 0, 0, 2'b01, 4'(mq[0].tag), 0, 8'($urandom), 0, 0);
    end
    idle(3);
    chk("drain_model_empty", empty_o, 1);
    chk("drain_scoreboard", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
